// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard unit: datapath stage controls in,
// stall/flush/forward controls and scoreboard status out.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
);
    logic [REG_AW-1:0] RsD, RtD, WriteRegD;
    logic              RegWriteD, MdD, JumpD, BranchD;
    logic [REG_AW-1:0] RsE, RtE, WriteRegE, MdDestE;
    logic              RegWriteE, MemtoRegE, MdStartE;
    logic [REG_AW-1:0] WriteRegM, WriteRegW;
    logic              RegWriteM, MemtoRegM, RegWriteW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              ForwardAD, ForwardBD;
    logic              StallF, StallD, FlushE;
    logic              MdBusy, MdWbW;
    logic [REG_AW-1:0] MdDest;
    logic [PERF_W-1:0] StallCount;

    modport master (
        output RsD, RtD, WriteRegD, RegWriteD, MdD, JumpD, BranchD,
               RsE, RtE, WriteRegE, MdDestE, RegWriteE, MemtoRegE, MdStartE,
               WriteRegM, WriteRegW, RegWriteM, MemtoRegM, RegWriteW,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, MdBusy, MdWbW, MdDest, StallCount
    );

    modport slave (
        input  RsD, RtD, WriteRegD, RegWriteD, MdD, JumpD, BranchD,
               RsE, RtE, WriteRegE, MdDestE, RegWriteE, MemtoRegE, MdStartE,
               WriteRegM, WriteRegW, RegWriteM, MemtoRegM, RegWriteW,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, MdBusy, MdWbW, MdDest, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// MIPS hazard unit: M/W forwarding, load-use/branch stalls, jump flush, a
// single-entry multiply/divide scoreboard and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4,
    parameter int PERF_W     = 16
) (
    input logic           clk,
    input logic           rst,
    hazard_scoreboard_if.slave hz
);
    localparam logic [CNT_W-1:0] MD_LAT = CNT_W'(MD_LATENCY);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [PERF_W-1:0] stall_count_q, stall_count_d;

    logic [1:0][REG_AW-1:0] src_e, src_d;
    logic [1:0][1:0]        fwd_e;
    logic [1:0]             fwd_d, raw_hit, lw_hit, br_e_hit, br_m_hit;

    logic              md_busy, md_issue, pact;
    logic [REG_AW-1:0] pend;
    logic              waw_hit, lwstall, brstall, mdstall, stall;

    assign src_e = {hz.RtE, hz.RsE};
    assign src_d = {hz.RtD, hz.RsD};

    // A pending issue in E is already visible to D, so the scoreboard
    // covers the issue cycle without waiting for the countdown to load.
    assign md_busy  = (cnt_q != '0);
    assign md_issue = hz.MdStartE && !md_busy;
    assign pact     = hz.MdStartE || md_busy;
    assign pend     = hz.MdStartE ? hz.MdDestE : dest_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign fwd_e[gi] =
                ((src_e[gi] != '0) && hz.RegWriteM && (src_e[gi] == hz.WriteRegM)) ? 2'b10 :
                ((src_e[gi] != '0) && hz.RegWriteW && (src_e[gi] == hz.WriteRegW)) ? 2'b01 :
                                                                                      2'b00;
            assign fwd_d[gi]    = (src_d[gi] != '0) && hz.RegWriteM && (src_d[gi] == hz.WriteRegM);
            assign raw_hit[gi]  = (pend != '0) && (src_d[gi] == pend);
            assign lw_hit[gi]   = (src_d[gi] == hz.WriteRegE);
            assign br_e_hit[gi] = (src_d[gi] == hz.WriteRegE);
            assign br_m_hit[gi] = (src_d[gi] == hz.WriteRegM);
        end
    endgenerate

    assign waw_hit = hz.RegWriteD && (pend != '0) && (hz.WriteRegD == pend);
    assign lwstall = hz.MemtoRegE && (|lw_hit);
    assign brstall = hz.BranchD && ((hz.RegWriteE && (|br_e_hit)) ||
                                    (hz.MemtoRegM && (|br_m_hit)));
    assign mdstall = pact && ((|raw_hit) || waw_hit || hz.MdD);
    assign stall   = lwstall || brstall || mdstall;

    always_comb begin
        cnt_d         = cnt_q;
        dest_d        = dest_q;
        stall_count_d = stall_count_q;
        // An issue while busy is a protocol violation and leaves state alone.
        if (md_issue) begin
            cnt_d  = MD_LAT;
            dest_d = hz.MdDestE;
        end else if (md_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            dest_q        <= '0;
            stall_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            dest_q        <= dest_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.ForwardAE  = fwd_e[0];
    assign hz.ForwardBE  = fwd_e[1];
    assign hz.ForwardAD  = fwd_d[0];
    assign hz.ForwardBD  = fwd_d[1];
    assign hz.StallF     = stall;
    assign hz.StallD     = stall;
    assign hz.FlushE     = stall || hz.JumpD;
    assign hz.MdBusy     = md_busy;
    assign hz.MdWbW      = (cnt_q == CNT_W'(1));
    assign hz.MdDest     = dest_q;
    assign hz.StallCount = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a vector table for the combinational hazard paths with an
// idle scoreboard, then hand-written multi-cycle scoreboard sequences.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .PERF_W(16)) hz ();

    hazard_scoreboard #(
        .REG_AW(5), .MD_LATENCY(4), .CNT_W(4), .PERF_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    typedef struct packed {
        logic [4:0] rsd, rtd;
        logic       br, jp;
        logic [4:0] rse, rte, wre;
        logic       rwe, m2re;
        logic [4:0] wrm;
        logic       rwm, m2rm;
        logic [4:0] wrw;
        logic       rww;
        logic [1:0] fae, fbe;
        logic       fad, fbd, stall, flush;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hz.RsD = '0; hz.RtD = '0; hz.WriteRegD = '0; hz.RegWriteD = 1'b0;
        hz.MdD = 1'b0; hz.JumpD = 1'b0; hz.BranchD = 1'b0;
        hz.RsE = '0; hz.RtE = '0; hz.WriteRegE = '0; hz.MdDestE = '0;
        hz.RegWriteE = 1'b0; hz.MemtoRegE = 1'b0; hz.MdStartE = 1'b0;
        hz.WriteRegM = '0; hz.WriteRegW = '0;
        hz.RegWriteM = 1'b0; hz.MemtoRegM = 1'b0; hz.RegWriteW = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},  32'(hz.MdBusy),     32'd0);
        chk({tag, "_wb"},    32'(hz.MdWbW),      32'd0);
        chk({tag, "_dest"},  32'(hz.MdDest),     32'd0);
        chk({tag, "_count"}, 32'(hz.StallCount), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        // rsd rtd br jp | rse rte wre rwe m2re | wrm rwm m2rm | wrw rww || fae fbe fad fbd stall flush
        vec[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[6]  = '{5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[8]  = '{5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[9]  = '{5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[11] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("init");
        tick();

        // Combinational table with the scoreboard idle
        for (int i = 0; i < 12; i++) begin
            set_idle();
            hz.RsD = vec[i].rsd; hz.RtD = vec[i].rtd;
            hz.BranchD = vec[i].br; hz.JumpD = vec[i].jp;
            hz.RsE = vec[i].rse; hz.RtE = vec[i].rte; hz.WriteRegE = vec[i].wre;
            hz.RegWriteE = vec[i].rwe; hz.MemtoRegE = vec[i].m2re;
            hz.WriteRegM = vec[i].wrm; hz.RegWriteM = vec[i].rwm; hz.MemtoRegM = vec[i].m2rm;
            hz.WriteRegW = vec[i].wrw; hz.RegWriteW = vec[i].rww;
            @(negedge clk);
            $display("vec %0d: fae=%b fbe=%b fad=%b fbd=%b stall=%b flush=%b",
                     i, hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD, hz.StallD, hz.FlushE);
            chk($sformatf("vec%0d_fae", i),    32'(hz.ForwardAE), 32'(vec[i].fae));
            chk($sformatf("vec%0d_fbe", i),    32'(hz.ForwardBE), 32'(vec[i].fbe));
            chk($sformatf("vec%0d_fad", i),    32'(hz.ForwardAD), 32'(vec[i].fad));
            chk($sformatf("vec%0d_fbd", i),    32'(hz.ForwardBD), 32'(vec[i].fbd));
            chk($sformatf("vec%0d_stalld", i), 32'(hz.StallD),    32'(vec[i].stall));
            chk($sformatf("vec%0d_stallf", i), 32'(hz.StallF),    32'(vec[i].stall));
            chk($sformatf("vec%0d_flush", i),  32'(hz.FlushE),    32'(vec[i].flush));
            tick();
        end
        set_idle();
        @(negedge clk);
        chk("table_stall_count", 32'(hz.StallCount), 32'd3);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("rst2");
        tick();

        // MD RAW: issue to reg 8, D reads reg 8 until the countdown drains
        set_idle();
        hz.MdStartE = 1'b1; hz.MdDestE = 5'd8; hz.RsD = 5'd8;
        @(negedge clk);
        $display("raw cycle 0: stall=%b busy=%b", hz.StallD, hz.MdBusy);
        chk("raw_c0_stall", 32'(hz.StallD), 32'd1);
        chk("raw_c0_busy",  32'(hz.MdBusy), 32'd0);
        tick();
        hz.MdStartE = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            $display("raw cycle %0d: stall=%b busy=%b wb=%b", c, hz.StallD, hz.MdBusy, hz.MdWbW);
            chk($sformatf("raw_c%0d_stall", c), 32'(hz.StallD), 32'd1);
            chk($sformatf("raw_c%0d_busy", c),  32'(hz.MdBusy), 32'd1);
            chk($sformatf("raw_c%0d_wb", c),    32'(hz.MdWbW),  (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge clk);
        $display("raw cycle 5: stall=%b busy=%b count=%0d", hz.StallD, hz.MdBusy, hz.StallCount);
        chk("raw_c5_stall", 32'(hz.StallD),     32'd0);
        chk("raw_c5_busy",  32'(hz.MdBusy),     32'd0);
        chk("raw_c5_wb",    32'(hz.MdWbW),      32'd0);
        chk("raw_c5_count", 32'(hz.StallCount), 32'd5);
        tick();

        // WAW and structural stalls against reg 9
        set_idle();
        hz.MdStartE = 1'b1; hz.MdDestE = 5'd9;
        @(negedge clk);
        chk("waw_issue_stall", 32'(hz.StallD), 32'd0);
        tick();
        hz.MdStartE = 1'b0; hz.RegWriteD = 1'b1; hz.WriteRegD = 5'd9;
        @(negedge clk);
        $display("waw dest9: stall=%b mddest=%0d", hz.StallD, hz.MdDest);
        chk("waw_same_stall", 32'(hz.StallD), 32'd1);
        chk("waw_mddest",     32'(hz.MdDest), 32'd9);
        tick();
        hz.WriteRegD = 5'd10;
        @(negedge clk);
        $display("waw dest10: stall=%b", hz.StallD);
        chk("waw_other_stall", 32'(hz.StallD), 32'd0);
        tick();
        hz.RegWriteD = 1'b0; hz.WriteRegD = '0; hz.MdD = 1'b1;
        @(negedge clk);
        chk("struct_c3_stall", 32'(hz.StallD), 32'd1);
        tick();
        @(negedge clk);
        $display("struct last busy: stall=%b wb=%b", hz.StallD, hz.MdWbW);
        chk("struct_c4_stall", 32'(hz.StallD), 32'd1);
        chk("struct_c4_wb",    32'(hz.MdWbW),  32'd1);
        tick();
        @(negedge clk);
        $display("struct free: stall=%b busy=%b", hz.StallD, hz.MdBusy);
        chk("struct_c5_stall", 32'(hz.StallD), 32'd0);
        chk("struct_c5_busy",  32'(hz.MdBusy), 32'd0);
        tick();

        // Register 0 destination never stalls; a mid-op issue is ignored
        set_idle();
        for (int c = 0; c <= 5; c++) begin
            hz.MdStartE = (c == 0) || (c == 2);
            hz.MdDestE  = (c == 2) ? 5'd5 : 5'd0;
            @(negedge clk);
            $display("reg0 cycle %0d: stall=%b busy=%b wb=%b dest=%0d", c, hz.StallD, hz.MdBusy, hz.MdWbW, hz.MdDest);
            chk($sformatf("reg0_c%0d_stall", c), 32'(hz.StallD), 32'd0);
            chk($sformatf("reg0_c%0d_busy", c),  32'(hz.MdBusy), (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("reg0_c%0d_wb", c),    32'(hz.MdWbW),  (c == 4) ? 32'd1 : 32'd0);
            if (c == 3) chk("reg0_c3_dest", 32'(hz.MdDest), 32'd0);
            tick();
        end

        // Reset while cnt == 2, then a fresh issue
        set_idle();
        hz.MdStartE = 1'b1; hz.MdDestE = 5'd8; hz.RsD = 5'd8;
        @(negedge clk);
        tick();
        hz.MdStartE = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_pre_busy",  32'(hz.MdBusy), 32'd1);
        chk("rstmid_pre_stall", 32'(hz.StallD), 32'd1);
        tick();
        rst = 1'b0; hz.RsD = '0;
        @(negedge clk);
        $display("rst mid-op: busy=%b wb=%b count=%0d", hz.MdBusy, hz.MdWbW, hz.StallCount);
        chk_reset_state("rstmid");
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("rstmid_nowb%0d", c), 32'(hz.MdWbW), 32'd0);
        end
        tick();
        hz.MdStartE = 1'b1; hz.MdDestE = 5'd12;
        @(negedge clk);
        tick();
        hz.MdStartE = 1'b0;
        @(negedge clk);
        $display("reissue: busy=%b dest=%0d", hz.MdBusy, hz.MdDest);
        chk("reissue_busy", 32'(hz.MdBusy), 32'd1);
        chk("reissue_dest", 32'(hz.MdDest), 32'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised next-generation hazard unit for the pipelined MIPS core. It keeps the classic hazard functions: E-stage forwarding from M/W, D-stage branch-operand forwarding from M, load-use stalls, branch stalls and jump flush. It adds a registered scoreboard for one outstanding multi-cycle multiply/divide (MD) operation and a saturating stall-cycle performance counter. It sits beside the datapath and drives the F/D/E pipeline-register enables, flushes and forwarding muxes.

## Interface
- REG_AW, 5, register-address width
- MD_LATENCY, 4, cycles from MD issue in E to MD result write (legal range 2..2^CNT_W-1)
- CNT_W, 4, MD countdown width
- PERF_W, 16, stall-counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- RsD, RtD  in  REG_AW  D-stage source registers
- RegWriteD  in  1  D-stage instruction writes a GPR
- WriteRegD  in  REG_AW  D-stage destination
- MdD  in  1  D-stage instruction is an MD op
- JumpD, BranchD  in  1  D-stage jump / branch
- RsE, RtE, WriteRegE  in  REG_AW  E-stage registers
- RegWriteE, MemtoRegE  in  1  E-stage controls
- MdStartE  in  1  E-stage instruction is a valid MD op (issue pulse)
- MdDestE  in  REG_AW  MD destination register
- WriteRegM, RegWriteM, MemtoRegM  in  REG_AW/1/1  M-stage controls
- WriteRegW, RegWriteW  in  REG_AW/1  W-stage controls
- ForwardAE, ForwardBE  out  2  10 = from M, 01 = from W, 00 = register file
- ForwardAD, ForwardBD  out  1  branch comparator forwards from M
- StallF, StallD, FlushE  out  1  pipeline control
- MdBusy  out  1  MD operation outstanding (registered)
- MdDest  out  REG_AW  destination of outstanding MD op (registered)
- MdWbW  out  1  MD result uses the second register-file write port this cycle
- StallCount  out  PERF_W  saturating count of cycles with StallD = 1

## Operation
- Forwarding: E-stage priority is M over W. No forwarding for register 0. ForwardAD/BD are set when RsD/RtD is nonzero, equals WriteRegM, and RegWriteM = 1.
- lwstall = MemtoRegE && (RsD == WriteRegE || RtD == WriteRegE).
- brstall = BranchD && ((RegWriteE && WriteRegE ∈ {RsD, RtD}) || (MemtoRegM && WriteRegM ∈ {RsD, RtD})).
- Scoreboard state:
  - cnt[CNT_W-1:0] and dest[REG_AW-1:0].
  - When MdStartE = 1 and cnt == 0: cnt <= MD_LATENCY, dest <= MdDestE.
  - Otherwise, when cnt != 0: cnt <= cnt − 1.
  - The countdown runs regardless of stalls.
- MdBusy = (cnt != 0). MdWbW = (cnt == 1). MdDest = dest.
- MdStartE while cnt != 0 is a protocol violation. It is ignored: the state is unchanged.
- Effective pending destination: pend = MdStartE ? MdDestE : dest. Pending is active when pact = MdStartE || MdBusy.
- mdstall is asserted when pact holds and any of the following is true:
  - RAW: RsD == pend or RtD == pend, with pend != 0.
  - WAW: RegWriteD && WriteRegD == pend, with pend != 0.
  - Structural: MdD = 1 (a second MD op waits).
- A read of pend stalls through the cycle where cnt == 1. The D-stage read happens the cycle after the write-back.
- StallF = StallD = lwstall || brstall || mdstall.
- FlushE = lwstall || brstall || mdstall || JumpD.
- StallCount increments when StallD = 1 and saturates at all-ones.
- On rst: cnt, dest and StallCount clear to 0, so MdBusy = 0, MdWbW = 0 and MdDest = 0. Combinational outputs follow their inputs. An in-flight MD op is abandoned.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the registered scoreboard, with zero latency.
- MdStartE high at edge k: MdBusy = 1 from k+1 through k+MD_LATENCY, and 0 after edge k+MD_LATENCY.
- MdWbW is high for exactly one cycle, the last busy cycle (between edges k+MD_LATENCY−1 and k+MD_LATENCY).
- A dependent D instruction is held from the issue cycle through the MdWbW cycle. It advances on the first cycle with MdBusy = 0.
- Back-to-back MD ops: the second MdStartE can be accepted in the first cycle with MdBusy = 0.
- rst has priority over MdStartE in the same cycle.

## Test plan
- MD RAW: MD_LATENCY = 4, MdStartE = 1 with MdDestE = 8 at cycle 0, then RsD = 8 held. Required: StallD = 1 for cycles 0–4, MdWbW = 1 in cycle 4, StallD = 0 in cycle 5, StallCount = 5.
- WAW and structural stalls: with MdDest = 9 busy, apply RegWriteD = 1, WriteRegD = 9 and check stall. Apply WriteRegD = 10 and check no stall. Apply MdD = 1 and check stall until MdBusy = 0.
- Register 0: MdDestE = 0 with RsD = 0. Required: no stall, while MdBusy still counts 4 cycles.
- Forwarding priority: RsE = 3, WriteRegM = WriteRegW = 3, both RegWrite = 1 → ForwardAE = 10. With RegWriteM = 0 → 01. With RsE = 0 → 00.
- Load-use and branch: MemtoRegE = 1, WriteRegE = 5, RtD = 5 → StallF = StallD = FlushE = 1. BranchD = 1 with MemtoRegM = 1, WriteRegM = 6, RsD = 6 → stall. JumpD alone → only FlushE = 1.
- Reset mid-op: rst at cnt = 2. Required: next cycle MdBusy = 0, MdWbW never pulses, StallCount = 0. A subsequent MdStartE is accepted normally.
